conv_encoder_k3: RTL and testbench
==================================

Name: conv_encoder_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder; the transmit-side counterpart of the Viterbi decoder's 4-state trellis (BMU/ACSU/traceback).
- Encodes a frame of FRAME_LEN information bits.
- Appends K-1 = 2 zero tail bits so the trellis terminates in state 00.
- Emits one 2-bit code symbol per accepted bit over a valid/ready stream with a registered output stage.
- Feeds the channel model and decoder testbenches, and forms the TX half of loopback.

Parameters:
FRAME_LEN, 8, information bits per frame (>= 1); tail bits not counted
G0, 3'b111, generator for o_sym[1], taps {u, s1, s0} MSB-first (octal 7)
G1, 3'b101, generator for o_sym[0], taps {u, s1, s0} MSB-first (octal 5)

Ports:
i_clk  in  1  clock, rising-edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  frame start request; sampled only in IDLE
i_bit  in  1  information bit
i_valid  in  1  i_bit valid
o_ready  out  1  encoder accepts i_bit this cycle
o_sym  out  2  code symbol {c0,c1}; c0 from G0, c1 from G1
o_valid  out  1  o_sym valid
i_ready  in  1  downstream accepts o_sym
o_sof  out  1  qualifies first symbol of frame (valid with o_valid)
o_eof  out  1  qualifies last tail symbol of frame (valid with o_valid)
o_busy  out  1  high in DATA or TAIL, or while output register holds an unaccepted symbol
o_state  out  2  current trellis state {s1,s0}; s1 = most recent bit

Behaviour:
- Reset (i_rst=1 at clock edge), applies in any state including mid-frame:
  - FSM=IDLE; {s1,s0}=00; bit counter=0; tail counter=0.
  - o_valid=0, o_sym=00, o_sof=0, o_eof=0, o_ready=0, o_busy=0.
  - Partial frame discarded; no eof emitted.
- Encoding, for input u (data bit or tail 0):
  - c0 = ^(G0 & {u,s1,s0}); c1 = ^(G1 & {u,s1,s0}).
  - Next state {s1,s0} <= {u,s1}.
- Output slot free: slot_free = !o_valid || i_ready.
- On each encode: o_sym, o_sof, o_eof are registered; latency is 1 cycle from input acceptance to o_valid.
- Backpressure: while o_valid && !i_ready, o_sym/o_sof/o_eof/o_valid hold stable and no encode occurs.
- o_valid clears on the cycle after acceptance if nothing new is encoded.
- FSM states:
  - IDLE: o_ready=0. If i_start=1: clear {s1,s0} and counters, go to DATA. i_start is ignored in DATA and TAIL.
  - DATA: o_ready = slot_free. On i_valid && o_ready: encode i_bit, increment bit counter. The first encode of the frame sets o_sof=1. When the FRAME_LEN-th bit is accepted, go to TAIL on the next cycle.
  - TAIL: o_ready=0. When slot_free, encode u=0 without a handshake, once per cycle, twice total. The second tail encode sets o_eof=1 and returns to IDLE. {s1,s0} is 00 on entering IDLE.
- i_valid without o_ready: bit not consumed. Upstream holds it; no internal buffering.
- Throughput: 1 symbol/cycle with i_ready=1 continuous.
  - Frame = FRAME_LEN + 2 symbols.
  - New i_start is honoured the cycle after TAIL->IDLE, even if the final symbol is still awaiting i_ready. The first new symbol waits for slot_free.
- FRAME_LEN=1: the single symbol carries o_sof; the second tail symbol carries o_eof. sof and eof are never on the same symbol.
- Bit counter width $clog2(FRAME_LEN+1). No wrap within a frame.
- o_state reflects registered {s1,s0}, updated on the same edge as o_sym.

Test Plan:
- Reset then FRAME_LEN=4, i_start, bits 1,0,1,1, i_ready=1 -> o_sym 11,10,00,01,01,11 on consecutive cycles. o_sof on the 1st symbol, o_eof on the 6th. o_state after the frame = 00.
- Same frame, i_ready low 3 cycles while the 2nd symbol (10) is valid -> 10 held stable, o_ready=0 during the stall, no skipped or duplicated symbols. Final sequence unchanged.
- All-zero frame, FRAME_LEN=8 -> ten symbols 00; sof on the first, eof on the last.
- i_start pulsed in DATA and in TAIL -> ignored; frame length stays FRAME_LEN+2. Back-to-back frames: second i_start the cycle after eof encode -> second frame's first symbol recomputed from state 00.
- i_rst asserted after 2 data bits accepted -> next cycle o_valid=0, o_busy=0, o_state=00. A new frame of 1,0,1,1 reproduces 11,10,00,01,01,11.
- Random bits, random i_valid/i_ready gaps, 200 frames -> symbols match a reference model. Exactly one sof and one eof per frame. Each frame is decodable by the Viterbi chain with zero errors.

Source files
------------

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail termination.
// One registered 2-bit symbol per accepted bit over a valid/ready stream.
module conv_encoder_k3 #(
    parameter int         FRAME_LEN = 8,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_bit,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [1:0] o_sym,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_busy,
    output logic [1:0] o_state
);

    localparam int              CntW    = $clog2(FRAME_LEN + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {Idle, Data, Tail} fsmT;

    typedef struct packed {
        logic [1:0] sym;
        logic       sof;
        logic       eof;
    } symT;

    fsmT             state, stateNxt;
    logic [1:0]      trellis, trellisNxt;
    logic [CntW-1:0] bitCnt, bitCntNxt;
    logic            tailCnt, tailCntNxt;
    symT             outReg, outNxt;
    logic            validReg, validNxt;
    logic            slotFree, encode, encU;
    logic [2:0]      taps;

    assign slotFree = !validReg || i_ready;
    // tail bits are always zero, so the encoder input is only i_bit in Data
    assign encU     = (state == Data) ? i_bit : 1'b0;
    assign taps     = {encU, trellis};

    always_comb begin
        stateNxt   = state;
        trellisNxt = trellis;
        bitCntNxt  = bitCnt;
        tailCntNxt = tailCnt;
        outNxt     = outReg;
        validNxt   = validReg;
        encode     = 1'b0;
        o_ready    = 1'b0;

        if (validReg && i_ready) begin
            validNxt   = 1'b0;
            outNxt.sof = 1'b0;
            outNxt.eof = 1'b0;
        end

        case (state)
            Idle: begin
                if (i_start) begin
                    stateNxt   = Data;
                    trellisNxt = 2'b00;
                    bitCntNxt  = '0;
                    tailCntNxt = 1'b0;
                end
            end
            Data: begin
                o_ready = slotFree;
                if (i_valid && slotFree) begin
                    encode    = 1'b1;
                    bitCntNxt = bitCnt + CntW'(1);
                    if (bitCnt == LastBit) stateNxt = Tail;
                end
            end
            Tail: begin
                if (slotFree) begin
                    encode     = 1'b1;
                    tailCntNxt = 1'b1;
                    if (tailCnt) stateNxt = Idle;
                end
            end
            default: stateNxt = Idle;
        endcase

        // an encode overrides the drain above: new symbol lands in the slot
        if (encode) begin
            outNxt.sym = {^(G0 & taps), ^(G1 & taps)};
            outNxt.sof = (state == Data) && (bitCnt == '0);
            outNxt.eof = (state == Tail) && tailCnt;
            validNxt   = 1'b1;
            trellisNxt = {encU, trellis[1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= Idle;
            trellis  <= 2'b00;
            bitCnt   <= '0;
            tailCnt  <= 1'b0;
            outReg   <= '0;
            validReg <= 1'b0;
        end else begin
            state    <= stateNxt;
            trellis  <= trellisNxt;
            bitCnt   <= bitCntNxt;
            tailCnt  <= tailCntNxt;
            outReg   <= outNxt;
            validReg <= validNxt;
        end
    end

    assign o_sym   = outReg.sym;
    assign o_sof   = outReg.sof;
    assign o_eof   = outReg.eof;
    assign o_valid = validReg;
    assign o_busy  = (state != Idle) || validReg;
    assign o_state = trellis;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: per-frame reference encoder feeding a scoreboard,
// directed frames with literal symbol lists, mid-frame reset, random traffic.
module tb_conv_encoder_k3;

    localparam int         FL = 4;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    logic       i_clk = 1'b0;
    logic       i_rst, i_start, i_bit, i_valid, i_ready;
    logic       o_ready, o_valid, o_sof, o_eof, o_busy;
    logic [1:0] o_sym, o_state;

    conv_encoder_k3 #(.FRAME_LEN(FL), .G0(G0), .G1(G1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_bit(i_bit),
        .i_valid(i_valid), .o_ready(o_ready), .o_sym(o_sym), .o_valid(o_valid),
        .i_ready(i_ready), .o_sof(o_sof), .o_eof(o_eof), .o_busy(o_busy),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] sym;
        logic       sof;
        logic       eof;
        logic [1:0] nxt;
    } expT;

    expT        expQ[$];
    expT        mdl[$];
    logic [1:0] obsQ[$];
    int         checks = 0;
    int         errors = 0;
    bit         randReady = 0, stallArm = 0, stallSeen = 0;
    int         stallLeft = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the frame is the bit list plus two zeros; each symbol is the
    // generator parity over the current bit and the two bits before it.
    function automatic void modelFrame(input logic [FL-1:0] bits);
        logic u, p1, p2;
        logic [2:0] w;
        mdl.delete();
        for (int i = 0; i < FL + 2; i++) begin
            u  = (i < FL) ? bits[i] : 1'b0;
            p1 = (i >= 1 && i - 1 < FL) ? bits[i-1] : 1'b0;
            p2 = (i >= 2 && i - 2 < FL) ? bits[i-2] : 1'b0;
            w  = {u, p1, p2};
            mdl.push_back('{sym: {^(G0 & w), ^(G1 & w)}, sof: (i == 0),
                            eof: (i == FL + 1), nxt: {u, p1}});
        end
    endfunction

    always @(posedge i_clk) begin
        #1;
        if (stallLeft > 0) begin
            i_ready = 1'b0;
            stallLeft--;
        end else if (stallArm && o_valid && o_sym == 2'b10 && !o_sof) begin
            i_ready   = 1'b0;
            stallLeft = 2;
            stallArm  = 0;
            stallSeen = 1;
        end else begin
            i_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard and stream-protocol checks, sampled mid-cycle.
    bit         holdPrev = 0;
    logic [3:0] held;
    always @(negedge i_clk) begin
        expT e;
        if (i_rst) begin
            holdPrev = 0;
        end else begin
            if (holdPrev) begin
                chk("hold_valid", 8'(o_valid), 8'd1);
                chk("hold_symbol", 8'({o_sym, o_sof, o_eof}), 8'(held));
            end
            if (o_valid && !i_ready) chk("ready_in_stall", 8'(o_ready), 8'd0);
            if (o_valid) begin
                chk("busy_with_valid", 8'(o_busy), 8'd1);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol actual=%b required=none at %0t", o_sym, $time);
                end else begin
                    chk("trellis_state", 8'(o_state), 8'(expQ[0].nxt));
                    if (i_ready) begin
                        e = expQ.pop_front();
                        chk("symbol", 8'(o_sym), 8'(e.sym));
                        chk("sof", 8'(o_sof), 8'(e.sof));
                        chk("eof", 8'(o_eof), 8'(e.eof));
                        obsQ.push_back(o_sym);
                    end
                end
            end
            holdPrev = o_valid && !i_ready;
            held     = {o_sym, o_sof, o_eof};
        end
    end

    task automatic startFrame();
        int n;
        i_start = 1'b1;
        for (n = 0; n < 1000; n++) begin
            @(negedge i_clk);
            if (o_ready) break;
        end
        chk("start_timeout", 8'(n < 1000), 8'd1);
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic sendBit(input logic b, input int gap);
        int n;
        i_valid = 1'b0;
        repeat (gap) begin
            i_bit = 1'($urandom);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b1;
        i_bit   = b;
        for (n = 0; n < 1000; n++) begin
            @(negedge i_clk);
            if (o_ready) break;
        end
        chk("bit_timeout", 8'(n < 1000), 8'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic runFrame(input logic [FL-1:0] bits, input bit gaps, input bit pulseTail);
        modelFrame(bits);
        foreach (mdl[i]) expQ.push_back(mdl[i]);
        startFrame();
        for (int i = 0; i < FL; i++) sendBit(bits[i], gaps ? $urandom_range(0, 2) : 0);
        if (pulseTail) begin
            i_start = 1'b1;
            @(posedge i_clk); #1;
            i_start = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge i_clk);
        chk("drain_left", 8'(expQ.size()), 8'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("idle_busy", 8'(o_busy), 8'd0);
        chk("idle_state", 8'(o_state), 8'd0);
    endtask

    // lit holds n symbols, first symbol in the highest used bit pair
    task automatic checkObs(input string name, input logic [23:0] lit, input int n);
        chk({name, "_count"}, 8'(obsQ.size()), 8'(n));
        for (int i = 0; i < n && i < obsQ.size(); i++)
            chk(name, 8'(obsQ[i]), 8'(lit[2*n-1-2*i -: 2]));
    endtask

    initial begin
        logic [11:0] pin;
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_bit = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", 8'(o_valid), 8'd0);
        chk("rst_sym", 8'(o_sym), 8'd0);
        chk("rst_sof_eof", 8'({o_sof, o_eof}), 8'd0);
        chk("rst_ready", 8'(o_ready), 8'd0);
        chk("rst_busy", 8'(o_busy), 8'd0);
        chk("rst_state", 8'(o_state), 8'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // pin the reference against the hand-worked 1,0,1,1 frame
        modelFrame(4'b1101);
        pin = 12'b11_10_00_01_01_11;
        for (int i = 0; i < 6; i++) chk("model_pin", 8'(mdl[i].sym), 8'(pin[11-2*i -: 2]));
        chk("model_pin_flags", 8'({mdl[0].sof, mdl[5].eof, mdl[5].nxt}), 8'b1100);

        obsQ.delete();
        runFrame(4'b1101, 0, 0);
        drain();
        checkObs("frame1011", 24'b11_10_00_01_01_11, 6);

        obsQ.delete();
        stallArm = 1;
        runFrame(4'b1101, 0, 0);
        drain();
        chk("stall_hit", 8'(stallSeen), 8'd1);
        checkObs("stall1011", 24'b11_10_00_01_01_11, 6);

        obsQ.delete();
        runFrame(4'b0000, 0, 1);
        drain();
        checkObs("zeros", 24'b0, 6);

        // back-to-back with a start pulse during tail of the first frame
        obsQ.delete();
        runFrame(4'b0110, 0, 1);
        runFrame(4'b1101, 0, 0);
        drain();
        checkObs("b2b_a", 24'b00_11_01_01_11_00_11_10_00_01_01_11, 12);

        // reset after two accepted bits
        modelFrame(4'b1101);
        foreach (mdl[i]) expQ.push_back(mdl[i]);
        startFrame();
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        expQ.delete();
        @(negedge i_clk);
        chk("midrst_valid", 8'(o_valid), 8'd0);
        chk("midrst_busy", 8'(o_busy), 8'd0);
        chk("midrst_state", 8'(o_state), 8'd0);
        chk("midrst_ready", 8'(o_ready), 8'd0);
        obsQ.delete();
        runFrame(4'b1101, 0, 0);
        drain();
        checkObs("after_rst", 24'b11_10_00_01_01_11, 6);

        randReady = 1;
        for (int f = 0; f < 200; f++) runFrame(FL'($urandom), 1, (f % 3) == 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
